// File: rtl/da_pkg.sv
// Shared definitions for the distributed-arithmetic FIR control slice:
// active-low ROM strobe levels, sequencer states and width helpers.
package da_pkg;

  localparam logic ON  = 1'b0;
  localparam logic OFF = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    RUN,
    FLUSH,
    DONE
  } state_t;

  // Counter widths never collapse to zero bits, even for a single partition/bit.
  function automatic int calc_pw(input int n_part);
    return (n_part > 1) ? $clog2(n_part) : 1;
  endfunction

  function automatic int calc_bw(input int bit_w);
    return (bit_w > 1) ? $clog2(bit_w) : 1;
  endfunction

endpackage

// File: rtl/da_load_ctr.sv
// ROM load bookkeeping: write pointer over all partitions, wrap handling and
// the flag telling the sequencer that a complete coefficient set is present.
module da_load_ctr
  import da_pkg::*;
#(
  parameter int N_PART = 2,
  parameter int ROM_AW = 4
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              wr_en,
  output logic [calc_pw(N_PART)+ROM_AW-1:0] rom_wr_addr,
  output logic                              coef_valid
);

  localparam int AW   = calc_pw(N_PART) + ROM_AW;
  localparam int LAST = N_PART * (2 ** ROM_AW) - 1;

  logic [AW-1:0] ptr;

  // Writing word 0 invalidates the set; writing the final word completes it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr         <= '0;
      rom_wr_addr <= '0;
      coef_valid  <= 1'b0;
    end else if (wr_en) begin
      rom_wr_addr <= ptr;
      if (ptr == '0)
        coef_valid <= 1'b0;
      if (ptr == AW'(LAST)) begin
        ptr        <= '0;
        coef_valid <= 1'b1;
      end else begin
        ptr <= ptr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/da_control_seq.sv
// Distributed-arithmetic FIR sequencer: streams coefficient words into the DA
// ROM, then walks bits x partitions with a one-cycle read-to-accumulate pipe.
module da_control_seq
  import da_pkg::*;
#(
  parameter int BIT_W  = 8,
  parameter int N_PART = 2,
  parameter int ROM_AW = 4
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              start,
  input  logic                              CLOAD,
  output logic                              busy,
  output logic                              done,
  output logic                              start_err,
  output logic                              coef_valid,
  output logic                              load_zreg,
  output logic                              acc_clr,
  output logic                              CEN,
  output logic                              WEN,
  output logic [calc_pw(N_PART)+ROM_AW-1:0] rom_wr_addr,
  output logic [calc_pw(N_PART)-1:0]        rom_part,
  output logic [calc_bw(BIT_W)-1:0]         bit_idx,
  output logic                              do_acc,
  output logic                              acc_sub,
  output logic                              do_shift
);

  localparam int PW = calc_pw(N_PART);
  localparam int BW = calc_bw(BIT_W);
  localparam logic [PW-1:0] LAST_P = PW'(N_PART - 1);
  localparam logic [BW-1:0] LAST_B = BW'(BIT_W - 1);

  state_t        state, state_n;
  logic [PW-1:0] part_n;
  logic [BW-1:0] bit_n;
  logic          err_n;
  logic          wr_en;
  logic          run_n;

  da_load_ctr #(
    .N_PART(N_PART),
    .ROM_AW(ROM_AW)
  ) u_load_ctr (
    .clk        (clk),
    .resetn     (resetn),
    .wr_en      (wr_en),
    .rom_wr_addr(rom_wr_addr),
    .coef_valid (coef_valid)
  );

  // rom_part/bit_idx double as the loop counters while in RUN.
  always_comb begin
    state_n = state;
    part_n  = rom_part;
    bit_n   = bit_idx;
    err_n   = 1'b0;
    wr_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && coef_valid) begin
          state_n = LATCH;
        end else begin
          err_n = start;
          wr_en = CLOAD;
        end
      end
      LATCH: begin
        state_n = RUN;
        part_n  = '0;
        bit_n   = '0;
      end
      RUN: begin
        if (rom_part == LAST_P) begin
          part_n = '0;
          if (bit_idx == LAST_B)
            state_n = FLUSH;
          else
            bit_n = bit_idx + BW'(1);
        end else begin
          part_n = rom_part + PW'(1);
        end
      end
      FLUSH:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    run_n = (state_n == RUN);
  end

  // Outputs are registered against the next state; the accumulate controls
  // lag the read they belong to by one cycle to cover the ROM latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      start_err <= 1'b0;
      load_zreg <= 1'b0;
      acc_clr   <= 1'b0;
      CEN       <= OFF;
      WEN       <= OFF;
      rom_part  <= '0;
      bit_idx   <= '0;
      do_acc    <= 1'b0;
      acc_sub   <= 1'b0;
      do_shift  <= 1'b0;
    end else begin
      state     <= state_n;
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      start_err <= err_n;
      load_zreg <= (state_n == LATCH);
      acc_clr   <= (state_n == LATCH);
      CEN       <= (run_n || wr_en) ? ON : OFF;
      WEN       <= wr_en ? ON : OFF;
      rom_part  <= run_n ? part_n : '0;
      bit_idx   <= run_n ? bit_n : '0;
      do_acc    <= (state == RUN);
      acc_sub   <= (state == RUN) && (bit_idx == LAST_B);
      do_shift  <= (state == RUN) && (rom_part == LAST_P) && (bit_idx != LAST_B);
    end
  end

endmodule

// File: tb/tb_da_control_seq.sv
// Scoreboard bench for da_control_seq: default build plus a BIT_W=4, N_PART=1
// build; expected activity records are queued and checked by per-DUT monitors.
module tb_da_control_seq;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [19:0] MASK_FULL = 20'hFFFFF;
  localparam logic [19:0] MASK_WR   = ~20'h00078;
  localparam logic [19:0] MASK_RD   = ~20'h00F80;
  localparam logic [19:0] MASK_IDLE = ~20'h00FF8;

  typedef struct {
    int          cyc;
    logic [19:0] vec;
    logic [19:0] mask;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  logic start_a, cload_a, start_b, cload_b;

  logic busy_a, done_a, serr_a, cv_a_o, lz_a, ac_a, cen_a, wen_a;
  logic [4:0] wa_a;
  logic [0:0] rp_a;
  logic [2:0] bi_a;
  logic da_a, as_a, ds_a;

  logic busy_b, done_b, serr_b, cv_b_o, lz_b, ac_b, cen_b, wen_b;
  logic [2:0] wa_b;
  logic [0:0] rp_b;
  logic [1:0] bi_b;
  logic da_b, as_b, ds_b;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   ptr_a = 0, ptr_b = 0;
  logic cv_a = 1'b0, cv_b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  da_control_seq #(.BIT_W(8), .N_PART(2), .ROM_AW(4)) dut_a (
    .clk(clk), .resetn(resetn), .start(start_a), .CLOAD(cload_a),
    .busy(busy_a), .done(done_a), .start_err(serr_a), .coef_valid(cv_a_o),
    .load_zreg(lz_a), .acc_clr(ac_a), .CEN(cen_a), .WEN(wen_a),
    .rom_wr_addr(wa_a), .rom_part(rp_a), .bit_idx(bi_a),
    .do_acc(da_a), .acc_sub(as_a), .do_shift(ds_a)
  );

  da_control_seq #(.BIT_W(4), .N_PART(1), .ROM_AW(2)) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .CLOAD(cload_b),
    .busy(busy_b), .done(done_b), .start_err(serr_b), .coef_valid(cv_b_o),
    .load_zreg(lz_b), .acc_clr(ac_b), .CEN(cen_b), .WEN(wen_b),
    .rom_wr_addr(wa_b), .rom_part(rp_b), .bit_idx(bi_b),
    .do_acc(da_b), .acc_sub(as_b), .do_shift(ds_b)
  );

  function automatic logic [19:0] mk(input logic bz, input logic dn, input logic se,
                                     input logic cv, input logic lz, input logic ac,
                                     input logic cen, input logic wen, input logic [4:0] wa,
                                     input logic rp, input logic [2:0] bi, input logic da,
                                     input logic asb, input logic dsh);
    return {bz, dn, se, cv, lz, ac, cen, wen, wa, rp, bi, da, asb, dsh};
  endfunction

  function automatic logic [19:0] pack_a();
    return mk(busy_a, done_a, serr_a, cv_a_o, lz_a, ac_a, cen_a, wen_a,
              wa_a, rp_a[0], bi_a, da_a, as_a, ds_a);
  endfunction

  function automatic logic [19:0] pack_b();
    return mk(busy_b, done_b, serr_b, cv_b_o, lz_b, ac_b, cen_b, wen_b,
              {2'b00, wa_b}, rp_b[0], {1'b0, bi_b}, da_b, as_b, ds_b);
  endfunction

  // done, start_err, load_zreg, any ROM access, or an accumulate
  function automatic logic active(input logic [19:0] v);
    return v[18] | v[17] | v[15] | ~v[13] | v[2];
  endfunction

  task automatic checkOutput(input string nm, input logic [19:0] act,
                             input logic [19:0] want, input logic [19:0] mask);
    total++;
    if (((act ^ want) & mask) != 20'h0) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h (mask %h)", nm, act, want, mask);
    end
  endtask

  task automatic pushE(input bit sel, input int c, input logic [19:0] v,
                       input logic [19:0] m, input string nm);
    exp_t e;
    e.cyc = c; e.vec = v; e.mask = m; e.name = nm;
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
  endtask

  task automatic expectErr(input bit sel, input int t0);
    logic cv;
    cv = sel ? cv_b : cv_a;
    pushE(sel, t0 + 1, mk(L,L,H,cv,L,L,H,H,5'd0,L,3'd0,L,L,L), MASK_IDLE, "start_err");
  endtask

  task automatic expectLoad(input bit sel, input int t0, input int n, input bit err_first);
    int p, words;
    logic cv;
    words = sel ? 4 : 32;
    for (int i = 0; i < n; i++) begin
      p  = sel ? ptr_b : ptr_a;
      cv = sel ? cv_b : cv_a;
      if (p == 0) cv = L;
      if (p == words - 1) cv = H;
      pushE(sel, t0 + 1 + i,
            mk(L, L, (i == 0) && err_first, cv, L, L, L, L, 5'(p), L, 3'd0, L, L, L),
            MASK_WR, "write");
      p = (p == words - 1) ? 0 : p + 1;
      if (sel) begin ptr_b = p; cv_b = cv; end
      else     begin ptr_a = p; cv_a = cv; end
    end
  endtask

  // keep = number of records (latch, reads, flush, done) expected to appear
  task automatic expectRun(input bit sel, input int t0, input int nb, input int np,
                           input int keep);
    logic cv;
    int r, j;
    cv = sel ? cv_b : cv_a;
    r  = nb * np;
    if (keep > 0)
      pushE(sel, t0 + 1, mk(H,L,L,cv,H,H,H,H,5'd0,L,3'd0,L,L,L), MASK_IDLE, "latch");
    for (int i = 0; i < r; i++) begin
      if (i + 1 < keep) begin
        j = i - 1;
        pushE(sel, t0 + 2 + i,
              mk(H, L, L, cv, L, L, L, H, 5'd0, 1'(i % np), 3'(i / np), i > 0,
                 (i > 0) && (j / np == nb - 1),
                 (i > 0) && (j % np == np - 1) && (j / np != nb - 1)),
              MASK_RD, "read");
      end
    end
    j = r - 1;
    if (keep > r + 1)
      pushE(sel, t0 + 2 + r,
            mk(H, L, L, cv, L, L, H, H, 5'd0, L, 3'd0, H, (j / np == nb - 1),
               (j % np == np - 1) && (j / np != nb - 1)),
            MASK_IDLE, "flush");
    if (keep > r + 2)
      pushE(sel, t0 + 3 + r, mk(H,H,L,cv,L,L,H,H,5'd0,L,3'd0,L,L,L), MASK_IDLE, "done");
  endtask

  task automatic applyStimulus(input bit sel, input logic s, input logic c, input int n);
    if (sel) begin start_b = s; cload_b = c; end
    else     begin start_a = s; cload_a = c; end
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon_a
    logic [19:0] v;
    exp_t e;
    v = pack_a();
    if (active(v)) begin
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("[TB] FAIL a_unexpected cyc=%0d got %h want no activity", cyc, v);
      end else begin
        e = qa.pop_front();
        if (e.cyc != cyc || ((v ^ e.vec) & e.mask) != 20'h0) begin
          bad++;
          $display("[TB] FAIL a_%s cyc=%0d got %h want %h at cyc %0d", e.name, cyc, v, e.vec, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [19:0] v;
    exp_t e;
    v = pack_b();
    if (active(v)) begin
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("[TB] FAIL b_unexpected cyc=%0d got %h want no activity", cyc, v);
      end else begin
        e = qb.pop_front();
        if (e.cyc != cyc || ((v ^ e.vec) & e.mask) != 20'h0) begin
          bad++;
          $display("[TB] FAIL b_%s cyc=%0d got %h want %h at cyc %0d", e.name, cyc, v, e.vec, e.cyc);
        end
      end
    end
  end

  initial begin
    resetn = 1'b0;
    start_a = 1'b0; cload_a = 1'b0; start_b = 1'b0; cload_b = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_a", pack_a(), mk(L,L,L,L,L,L,H,H,5'd0,L,3'd0,L,L,L), MASK_FULL);
    checkOutput("reset_b", pack_b(), mk(L,L,L,L,L,L,H,H,5'd0,L,3'd0,L,L,L), MASK_FULL);
    resetn = 1'b1;
    @(negedge clk);

    $display("[TB] start without coefficients");
    expectErr(0, cyc);
    applyStimulus(0, 1'b1, 1'b0, 1);
    applyStimulus(0, 1'b0, 1'b0, 3);
    checkOutput("err_not_busy", pack_a(), mk(L,L,L,L,L,L,H,H,5'd0,L,3'd0,L,L,L), 20'h82000);

    $display("[TB] full load of 32 words");
    expectLoad(0, cyc, 32, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32);
    applyStimulus(0, 1'b0, 1'b0, 2);

    $display("[TB] run with start and CLOAD held");
    expectRun(0, cyc, 8, 2, 99);
    applyStimulus(0, 1'b1, 1'b1, 19);
    applyStimulus(0, 1'b0, 1'b0, 3);

    $display("[TB] run with start pulse");
    expectRun(0, cyc, 8, 2, 99);
    applyStimulus(0, 1'b1, 1'b0, 1);
    applyStimulus(0, 1'b0, 1'b0, 20);

    $display("[TB] word 33 invalidates the set");
    expectLoad(0, cyc, 1, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 1);
    applyStimulus(0, 1'b0, 1'b0, 2);
    expectErr(0, cyc);
    applyStimulus(0, 1'b1, 1'b0, 1);
    applyStimulus(0, 1'b0, 1'b0, 2);

    $display("[TB] reload remaining 31 words, rejected start on the first");
    expectLoad(0, cyc, 31, 1'b1);
    applyStimulus(0, 1'b1, 1'b1, 1);
    applyStimulus(0, 1'b0, 1'b1, 30);
    applyStimulus(0, 1'b0, 1'b0, 2);

    $display("[TB] reset during RUN cycle 5");
    expectRun(0, cyc, 8, 2, 6);
    applyStimulus(0, 1'b1, 1'b0, 1);
    applyStimulus(0, 1'b0, 1'b0, 5);
    #1 resetn = 1'b0;
    #1 checkOutput("async_reset", pack_a(), mk(L,L,L,L,L,L,H,H,5'd0,L,3'd0,L,L,L), MASK_FULL);
    ptr_a = 0; cv_a = L; ptr_b = 0; cv_b = L;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 25);

    $display("[TB] BIT_W=4 N_PART=1 build");
    expectLoad(1, cyc, 4, 1'b0);
    applyStimulus(1, 1'b0, 1'b1, 4);
    applyStimulus(1, 1'b0, 1'b0, 2);
    expectRun(1, cyc, 4, 1, 99);
    applyStimulus(1, 1'b1, 1'b0, 1);
    applyStimulus(1, 1'b0, 1'b0, 10);

    total++;
    if (qa.size() != 0) begin
      bad++;
      $display("[TB] FAIL a_pending: got %0d records left want 0", qa.size());
    end
    total++;
    if (qb.size() != 0) begin
      bad++;
      $display("[TB] FAIL b_pending: got %0d records left want 0", qb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/da_control_seq.md
# da_control_seq

Parametrised distributed-arithmetic FIR sequencer: manages streaming of precomputed partial-sum words into the DA ROM, then runs a bit-serial evaluation over `BIT_W` sample bits and `N_PART` ROM partitions per bit. It sits between the sample/zreg datapath, the single-port DA ROM, and the shift-accumulator. It replaces the fixed 4-tap, single-pass control FSM with a generic bit × partition loop, a registered read-to-accumulate pipeline, two's-complement sign handling and load bookkeeping.

## Interface
- `BIT_W`, 8: sample width; the number of bit-serial passes per output.
- `N_PART`, 2: ROM partitions read sequentially per bit.
- `ROM_AW`, 4: address width per partition, so each partition holds 2^ROM_AW words.
- Derived: `PW = max(1,clog2(N_PART))`, `BW = max(1,clog2(BIT_W))`.

- `clk`  in  1  the single clock.
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  request one output computation.
- `CLOAD`  in  1  write strobe, one precomputed ROM word per cycle.
- `busy`  out  1  high while a computation is in flight.
- `done`  out  1  one-cycle pulse when the result is final.
- `start_err`  out  1  one-cycle pulse when `start` is rejected.
- `coef_valid`  out  1  the ROM holds a complete load.
- `load_zreg`  out  1  capture the input samples into zreg.
- `acc_clr`  out  1  clear the accumulator.
- `CEN`  out  1  ROM chip enable, active-low (ON=0).
- `WEN`  out  1  ROM write enable, active-low (ON=0).
- `rom_wr_addr`  out  PW+ROM_AW  write address as {partition, word}.
- `rom_part`  out  PW  partition being read.
- `bit_idx`  out  BW  sample bit that selects the ROM word.
- `do_acc`  out  1  add ROM data into the accumulator.
- `acc_sub`  out  1  subtract instead of add (MSB pass).
- `do_shift`  out  1  shift the accumulator right after this add.

## Operation
- All outputs are registered. Reset values: every output is 0, except `CEN` and `WEN`, which are 1 (OFF). Internal write pointer resets to 0 and `coef_valid` resets to 0. ROM contents are not cleared, but the ROM must be fully reloaded before `start` is honoured.
- States: IDLE, LATCH, RUN, FLUSH, DONE.
- IDLE with `start=1` and `coef_valid=1`: go to LATCH. `start` takes priority over a simultaneous `CLOAD`.
- IDLE with `start=1` and `coef_valid=0`: pulse `start_err`. A `CLOAD` in the same cycle is still performed.
- IDLE with `CLOAD=1` (load write): next cycle drives `CEN=0`, `WEN=0` and `rom_wr_addr` equal to the pointer, then the pointer increments.
  - A write at pointer 0 clears `coef_valid`.
  - A write at pointer N_PART·2^ROM_AW−1 sets `coef_valid` and wraps the pointer to 0.
- LATCH, one cycle: `load_zreg=1`, `acc_clr=1`, `busy=1`.
- RUN, BIT_W·N_PART cycles, iterating bit b (outer, from 0) and partition p (inner, from 0):
  - drives `CEN=0`, `WEN=1`, `rom_part=p`, `bit_idx=b`.
- Accumulate pipeline: one cycle after each RUN read (one-cycle ROM latency), the block asserts `do_acc=1` and drives:
  - `acc_sub` equal to (b==BIT_W−1);
  - `do_shift` equal to (p==N_PART−1 and b≠BIT_W−1).
- FLUSH, one cycle: `CEN=1`, and `do_acc` is issued for the final read.
- DONE, one cycle: `done=1`, `busy=1`, then return to IDLE.
- `start` and `CLOAD` while `busy=1` are ignored. No write occurs and no `start_err` pulses.
- Reset asserted mid-run: outputs go to their reset values immediately (asynchronously), the FSM returns to IDLE and no `done` pulse is issued.

## Timing
- `start` sampled at edge k:
  - `load_zreg`/`acc_clr` high in cycle k+1;
  - reads in cycles k+2 … k+1+BIT_W·N_PART;
  - `do_acc` in cycles k+3 … k+2+BIT_W·N_PART;
  - `done` in cycle k+3+BIT_W·N_PART.
- Defaults (BIT_W=8, N_PART=2): 16 reads, `done` at k+19.
- `busy` is high from k+1 through the `done` cycle inclusive. A new `start` is accepted at the edge ending the `done` cycle plus one (from IDLE).
- Load throughput is one word per cycle. A full load takes N_PART·2^ROM_AW `CLOAD` cycles; `coef_valid` rises one cycle after the last strobe.

## Structure
- Shared package `da_pkg` holds:
  - `ON`/`OFF` constants (0/1);
  - the state enum {IDLE, LATCH, RUN, FLUSH, DONE};
  - the PW/BW width helper functions.
- Sub-module `da_load_ctr` contains the write pointer, wrap logic and `coef_valid`. The FSM and bit/partition counters stay in the top.

## Test plan
- Load 32 words with defaults, then `start` → `coef_valid` rises after word 31; 16 reads with `rom_part` alternating 0,1; `acc_sub=1` only on the last 2 `do_acc` pulses; `done` at k+19.
- `start` after reset with no load → `start_err` pulses once; `busy` stays 0; no `CEN` activity.
- `start` plus `CLOAD` held during a run → no `WEN=0`, no restart, exactly one `done`.
- `resetn` dropped in RUN cycle 5 → `CEN=1` and `do_acc=0` immediately; `coef_valid=0`; no `done`.
- Write 33 words → `coef_valid` falls on word 33 (pointer 0) and stays 0 until 31 more words are written.
- BIT_W=4, N_PART=1 → 4 reads, `do_shift` high on the first 3 accumulates, `done` at k+7.
